// File: rtl/rom_ctrl_digest_cmp_if.sv
// Digest stream from the ROM digest comparator to the key manager.
// The master drives valid/word and the slave returns ready.
interface rom_ctrl_digest_cmp_if #(
    parameter int BeatW = 32
);
    logic             dig_valid;
    logic             dig_ready;
    logic [BeatW-1:0] dig_word;

    modport master (
        output dig_valid,
        output dig_word,
        input  dig_ready
    );

    modport slave (
        input  dig_valid,
        input  dig_word,
        output dig_ready
    );
endinterface

// File: rtl/rom_ctrl_digest_cmp.sv
// Compares DIGEST against EXP_DIGEST one beat of Lanes words at a time and streams each beat to the key manager.
// Defining ROM_CTRL_CMP_MISMATCH_IDX_EN adds a register that captures the first mismatching beat index.
module rom_ctrl_digest_cmp #(
    parameter int NumWords       = 8,
    parameter int WordW          = 32,
    parameter int Lanes          = 1,
    parameter int StopOnMismatch = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [NumWords*WordW-1:0]          digest_i,
    input  logic [NumWords*WordW-1:0]          exp_digest_i,
    rom_ctrl_digest_cmp_if.master              dig_if,
    output logic                               done_o,
    output logic [3:0]                         good_o,
    output logic [$clog2(NumWords/Lanes):0]    mismatch_idx_o,
    output logic                               alert_o
);

    localparam int NB    = NumWords / Lanes;
    localparam int IdxW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int MisW  = $clog2(NB) + 1;
    localparam int BeatW = Lanes * WordW;

    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NB - 1);
    localparam logic [3:0]      MuBiTrue  = 4'h6;
    localparam logic [3:0]      MuBiFalse = 4'h9;

    // Encodings are pairwise at least Hamming distance 3 apart.
    typedef enum logic [5:0] {
        StIdle     = 6'b001011,
        StChecking = 6'b010101,
        StDone     = 6'b101110,
        StError    = 6'b110000
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   shadow_q, shadow_d;
    logic              match_q, match_d;
    logic              early_stop_q, early_stop_d;
    logic [3:0]        good_q, good_d;

    logic [BeatW-1:0]  dig_beats [NB];
    logic [NB-1:0]     beat_eq;
    logic              beat_fire;
    logic              beat_bad;
    logic              dig_valid;
    logic [BeatW-1:0]  dig_word;
    logic              done;
    logic              fsm_alert;
    logic              cnt_alert;
    logic              state_alert;
    logic              start_alert;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_beat
            assign dig_beats[gi] = digest_i[gi*BeatW +: BeatW];
            assign beat_eq[gi]   = (digest_i[gi*BeatW +: BeatW] == exp_digest_i[gi*BeatW +: BeatW]);
        end
    endgenerate

    // The up and down counters must always sum to NB-1; any other sum means a glitched counter.
    assign cnt_alert   = ({1'b0, idx_q} + {1'b0, shadow_q}) != {1'b0, LastIdx};
    assign start_alert = start_i && (state_q != StIdle);
    assign beat_bad    = !beat_eq[idx_q];
    assign beat_fire   = (state_q == StChecking) && dig_if.dig_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        match_d      = match_q;
        early_stop_d = early_stop_q;
        dig_valid    = 1'b0;
        dig_word     = '0;
        done         = 1'b0;
        fsm_alert    = 1'b0;
        state_alert  = 1'b0;

        case (state_q)
            StIdle: begin
                if (idx_q != '0) begin
                    state_alert = 1'b1;
                end
                if (start_i) begin
                    state_d = StChecking;
                end
            end
            StChecking: begin
                dig_valid = 1'b1;
                dig_word  = dig_beats[idx_q];
                if (dig_if.dig_ready) begin
                    match_d = match_q & ~beat_bad;
                    if ((StopOnMismatch != 0) && beat_bad) begin
                        state_d      = StDone;
                        early_stop_d = 1'b1;
                    end else if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        shadow_d = shadow_q - 1'b1;
                    end
                end
            end
            StDone: begin
                done = 1'b1;
                if ((idx_q != LastIdx) && !early_stop_q) begin
                    state_alert = 1'b1;
                end
            end
            StError: begin
                done = 1'b1;
            end
            default: begin
                fsm_alert = 1'b1;
                state_d   = StError;
            end
        endcase

        if (cnt_alert) begin
            state_d = StError;
        end
    end

    // Verdict is derived from the next state so it is valid in the first Done cycle.
    assign good_d = ((state_d == StDone) && match_d) ? MuBiTrue : MuBiFalse;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            shadow_q     <= LastIdx;
            match_q      <= 1'b1;
            early_stop_q <= 1'b0;
            good_q       <= MuBiFalse;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            match_q      <= match_d;
            early_stop_q <= early_stop_d;
            good_q       <= good_d;
        end
    end

`ifdef ROM_CTRL_CMP_MISMATCH_IDX_EN
    logic [MisW-1:0] mis_idx_q, mis_idx_d;

    // All-ones doubles as the "nothing captured yet" marker; real indices never reach it.
    always_comb begin
        mis_idx_d = mis_idx_q;
        if (beat_fire && beat_bad && (mis_idx_q == {MisW{1'b1}})) begin
            mis_idx_d = MisW'(idx_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mis_idx_q <= {MisW{1'b1}};
        end else begin
            mis_idx_q <= mis_idx_d;
        end
    end

    assign mismatch_idx_o = mis_idx_q;
`else
    assign mismatch_idx_o = {MisW{1'b1}};
`endif

    assign dig_if.dig_valid = dig_valid;
    assign dig_if.dig_word  = dig_word;
    assign done_o           = done;
    assign good_o           = good_q;
    assign alert_o          = fsm_alert | cnt_alert | start_alert | state_alert
                              | (state_q == StError);

endmodule

// File: tb/tb_rom_ctrl_digest_cmp.sv
// Randomised bench for rom_ctrl_digest_cmp: three configurations share one stimulus stream
// and are compared every cycle against a beat-list model of the comparison.
module tb_rom_ctrl_digest_cmp;
    localparam int NumWords = 8;
    localparam int WordW    = 32;
    localparam int DW       = NumWords * WordW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ready;
    logic [DW-1:0] digest;
    logic [DW-1:0] exp_digest;

    logic       done0, done1, done2;
    logic [3:0] good0, good1, good2;
    logic [3:0] mis0, mis2;
    logic [2:0] mis1;
    logic       alert0, alert1, alert2;

    always #5 clk = ~clk;

    rom_ctrl_digest_cmp_if #(.BeatW(32)) if0 ();
    rom_ctrl_digest_cmp_if #(.BeatW(64)) if1 ();
    rom_ctrl_digest_cmp_if #(.BeatW(32)) if2 ();
    assign if0.dig_ready = ready;
    assign if1.dig_ready = ready;
    assign if2.dig_ready = ready;

    rom_ctrl_digest_cmp #(.NumWords(8), .WordW(32), .Lanes(1), .StopOnMismatch(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .digest_i(digest), .exp_digest_i(exp_digest),
        .dig_if(if0), .done_o(done0), .good_o(good0), .mismatch_idx_o(mis0), .alert_o(alert0));
    rom_ctrl_digest_cmp #(.NumWords(8), .WordW(32), .Lanes(2), .StopOnMismatch(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .digest_i(digest), .exp_digest_i(exp_digest),
        .dig_if(if1), .done_o(done1), .good_o(good1), .mismatch_idx_o(mis1), .alert_o(alert1));
    rom_ctrl_digest_cmp #(.NumWords(8), .WordW(32), .Lanes(1), .StopOnMismatch(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .digest_i(digest), .exp_digest_i(exp_digest),
        .dig_if(if2), .done_o(done2), .good_o(good2), .mismatch_idx_o(mis2), .alert_o(alert2));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per configuration, phase 0=idle, 1=sending beats, 2=finished.
    int lanes_m  [3] = '{1, 2, 1};
    bit stop_m   [3] = '{1'b0, 1'b0, 1'b1};
    int mis_ones [3] = '{15, 7, 15};
    int phase    [3];
    int sent     [3];
    bit bad      [3];
    int first_bad[3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_of(input logic [DW-1:0] v, input int k, input int b);
        logic [63:0] r;
        r = '0;
        for (int w = 0; w < lanes_m[k]; w++) r[w*32 +: 32] = v[(b*lanes_m[k]+w)*32 +: 32];
        return r;
    endfunction

    function automatic bit all_done();
        return (phase[0] == 2) && (phase[1] == 2) && (phase[2] == 2);
    endfunction

    task automatic get_obs(input int k, output logic v, output logic [63:0] w, output logic d,
                           output logic [3:0] g, output logic [63:0] m, output logic a);
        case (k)
            0:       begin v = if0.dig_valid; w = 64'(if0.dig_word); d = done0; g = good0; m = 64'(mis0); a = alert0; end
            1:       begin v = if1.dig_valid; w = 64'(if1.dig_word); d = done1; g = good1; m = 64'(mis1); a = alert1; end
            default: begin v = if2.dig_valid; w = 64'(if2.dig_word); d = done2; g = good2; m = 64'(mis2); a = alert2; end
        endcase
    endtask

    task automatic compare_all(input int k);
        logic v, d, a;
        logic [3:0] g;
        logic [63:0] w, m, em;
        logic ev, ed;
        get_obs(k, v, w, d, g, m, a);
        ev = (phase[k] == 1);
        ed = (phase[k] == 2);
        em = 64'(mis_ones[k]);
`ifdef ROM_CTRL_CMP_MISMATCH_IDX_EN
        if (first_bad[k] >= 0) em = 64'(first_bad[k]);
`endif
        check($sformatf("d%0d_valid", k), 64'(v), 64'(ev));
        check($sformatf("d%0d_word", k), w, ev ? beat_of(digest, k, sent[k]) : 64'd0);
        check($sformatf("d%0d_done", k), 64'(d), 64'(ed));
        check($sformatf("d%0d_good", k), 64'(g), (ed && !bad[k]) ? 64'h6 : 64'h9);
        check($sformatf("d%0d_mis_idx", k), m, em);
        check($sformatf("d%0d_alert", k), 64'(a), 64'(start && (phase[k] != 0)));
    endtask

    task automatic model_step(input int k, input logic st, input logic rdy);
        bit mm;
        if (phase[k] == 1 && rdy) begin
            mm = (beat_of(digest, k, sent[k]) != beat_of(exp_digest, k, sent[k]));
            if (mm) begin
                bad[k] = 1'b1;
                if (first_bad[k] < 0) first_bad[k] = sent[k];
            end
            sent[k]++;
            if (sent[k] == NumWords / lanes_m[k] || (stop_m[k] && mm)) phase[k] = 2;
        end else if (phase[k] == 0 && st) begin
            phase[k] = 1;
        end
    endtask

    // One clock: drive inputs just after the falling edge, compare, advance the model.
    task automatic cycle(input logic st, input logic rdy);
        start = st;
        ready = rdy;
        #1;
        for (int k = 0; k < 3; k++) compare_all(k);
        for (int k = 0; k < 3; k++) model_step(k, st, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            phase[k] = 0; sent[k] = 0; bad[k] = 1'b0; first_bad[k] = -1;
        end
        #1;
        for (int k = 0; k < 3; k++) compare_all(k);
        @(negedge clk);
    endtask

    function automatic logic rdy_for(input int mode, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'(n % 2);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_txn(input int txn, input int mode, input logic [7:0] mask);
        int n;
        for (int w = 0; w < NumWords; w++) digest[w*32 +: 32] = $urandom;
        exp_digest = digest;
        for (int w = 0; w < NumWords; w++)
            if (mask[w]) exp_digest[w*32 +: 32] = exp_digest[w*32 +: 32] ^ ($urandom | 32'd1);
        do_reset();
        repeat ($urandom_range(0, 3)) cycle(1'b0, 1'($urandom_range(0, 1)));
        cycle(1'b1, rdy_for(mode, 0));
        n = 0;
        while (!all_done() && n < 200) begin
            n++;
            cycle((mode == 2) && ($urandom_range(0, 15) == 0), rdy_for(mode, n));
        end
        check("txn_timeout", 64'(all_done()), 64'd1);
        repeat (2) cycle(1'b0, 1'b1);
        $display("txn %0d mode %0d mask %02h cycles %0d: good %h/%h/%h beats %0d/%0d/%0d",
                 txn, mode, mask, n, good0, good1, good2, sent[0], sent[1], sent[2]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0; digest = '0; exp_digest = '0;
        @(negedge clk);
        run_txn(0, 0, 8'h00);
        run_txn(1, 0, 8'h20);
        run_txn(2, 0, 8'h02);
        run_txn(3, 1, 8'h00);
        run_txn(4, 2, 8'h81);
        for (int t = 5; t < 25; t++)
            run_txn(t, $urandom_range(0, 2), ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom));

        // Stray start during Checking, then a reset in the middle of the walk.
        do_reset();
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        $display("txn stray-start: alert pulse issued, resetting mid-check");
        do_reset();

        // Corrupt the shadow counter of the first instance while it is mid-walk.
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        force dut0.shadow_q = 3'd0;
        #1;
        check("fault_alert_now", 64'(alert0), 64'd1);
        @(negedge clk);
        release dut0.shadow_q;
        #1;
        check("fault_err_done", 64'(done0), 64'd1);
        check("fault_err_good", 64'(good0), 64'h9);
        check("fault_err_valid", 64'(if0.dig_valid), 64'd0);
        check("fault_err_alert", 64'(alert0), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check("fault_alert_held", 64'(alert0), 64'd1);
        check("fault_done_held", 64'(done0), 64'd1);
        $display("txn shadow-fault: alert %0b done %0b good %h", alert0, done0, good0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
